gray_wptr_ctrl: RTL and testbench

Write-side pointer controller for a dual-clock FIFO. It holds the Gray-coded write pointer and advances it with a Gray incrementer (carry-in = accepted push). It synchronizes the remote Gray read pointer into the local clock domain and generates full, fill level and write-enable/address for the FIFO storage. It sits in the write clock domain, between the pushing client and the storage RAM/CDC boundary.

---
 rtl/gray_wptr_ctrl.sv | 83 ++++++++
 tb/tb_gray_wptr_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/gray_wptr_ctrl.sv
// Write-side pointer controller for a dual-clock FIFO: Gray write pointer,
// read-pointer synchronizer, full/level generation and storage write port.
module gray_wptr_ctrl #(
  parameter int AddrWidth  = 4,
  parameter int SyncStages = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  output logic                 full_o,
  output logic                 we_o,
  output logic [AddrWidth-1:0] waddr_o,
  output logic [AddrWidth:0]   wptr_gray_o,
  input  logic [AddrWidth:0]   rptr_gray_async_i,
  output logic [AddrWidth:0]   level_o,
  output logic                 drop_o
);

  localparam int PW = AddrWidth + 1;
  // Full when the two MSBs of the synchronized read pointer are inverted.
  localparam logic [PW-1:0] FullMask = PW'(3) << (AddrWidth - 1);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray_inc(input logic [PW-1:0] g, input logic ci);
    return bin2gray(gray2bin(g) + PW'(ci));
  endfunction

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] sync_q [SyncStages];
  logic [PW-1:0] sync_d [SyncStages];
  logic          drop_q, drop_d;

  logic [PW-1:0] rptr_sync;
  logic [PW-1:0] wbin;
  logic [PW-1:0] rbin_sync;
  logic          full;
  logic          we;

  always_comb begin
    sync_d[0] = rptr_gray_async_i;
    for (int i = 1; i < SyncStages; i++) sync_d[i] = sync_q[i-1];
  end

  always_comb begin
    rptr_sync = sync_q[SyncStages-1];
    wbin      = gray2bin(wptr_q);
    rbin_sync = gray2bin(rptr_sync);
    full      = (wptr_q == (rptr_sync ^ FullMask));
    we        = push_i & ~full;
    wptr_d    = gray_inc(wptr_q, we);
    drop_d    = push_i & full;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      drop_q <= 1'b0;
      for (int i = 0; i < SyncStages; i++) sync_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      drop_q <= drop_d;
      for (int i = 0; i < SyncStages; i++) sync_q[i] <= sync_d[i];
    end
  end

  assign full_o      = full;
  assign we_o        = we;
  assign waddr_o     = wbin[AddrWidth-1:0];
  assign wptr_gray_o = wptr_q;
  assign level_o     = wbin - rbin_sync;
  assign drop_o      = drop_q;

endmodule

// File: tb/tb_gray_wptr_ctrl.sv
// Bench for gray_wptr_ctrl: directed steps on a 4-deep instance, then random
// push/read traffic on several parameterizations against a counting model.
module tb_gray_wptr_ctrl;

  localparam int N = 4;
  localparam int AW[N] = '{2, 1, 4, 8};
  localparam int SS[N] = '{2, 2, 3, 2};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       push   [N];
  logic [8:0] rptr_a [N];

  logic       full_x [N];
  logic       we_x   [N];
  logic       drop_x [N];
  logic [8:0] wptr_x [N];
  logic [8:0] level_x[N];
  logic [8:0] waddr_x[N];

  logic [2:0] wptr0, level0;
  logic [1:0] waddr0;
  logic [1:0] wptr1, level1;
  logic [0:0] waddr1;
  logic [4:0] wptr2, level2;
  logic [3:0] waddr2;
  logic [8:0] wptr3, level3;
  logic [7:0] waddr3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gray_wptr_ctrl #(.AddrWidth(2), .SyncStages(2)) d0 (
    .clk_i(clk), .rst_ni(rst_n), .push_i(push[0]), .full_o(full_x[0]), .we_o(we_x[0]),
    .waddr_o(waddr0), .wptr_gray_o(wptr0), .rptr_gray_async_i(rptr_a[0][2:0]),
    .level_o(level0), .drop_o(drop_x[0]));
  gray_wptr_ctrl #(.AddrWidth(1), .SyncStages(2)) d1 (
    .clk_i(clk), .rst_ni(rst_n), .push_i(push[1]), .full_o(full_x[1]), .we_o(we_x[1]),
    .waddr_o(waddr1), .wptr_gray_o(wptr1), .rptr_gray_async_i(rptr_a[1][1:0]),
    .level_o(level1), .drop_o(drop_x[1]));
  gray_wptr_ctrl #(.AddrWidth(4), .SyncStages(3)) d2 (
    .clk_i(clk), .rst_ni(rst_n), .push_i(push[2]), .full_o(full_x[2]), .we_o(we_x[2]),
    .waddr_o(waddr2), .wptr_gray_o(wptr2), .rptr_gray_async_i(rptr_a[2][4:0]),
    .level_o(level2), .drop_o(drop_x[2]));
  gray_wptr_ctrl #(.AddrWidth(8), .SyncStages(2)) d3 (
    .clk_i(clk), .rst_ni(rst_n), .push_i(push[3]), .full_o(full_x[3]), .we_o(we_x[3]),
    .waddr_o(waddr3), .wptr_gray_o(wptr3), .rptr_gray_async_i(rptr_a[3][8:0]),
    .level_o(level3), .drop_o(drop_x[3]));

  assign wptr_x[0] = 9'(wptr0);  assign level_x[0] = 9'(level0);  assign waddr_x[0] = 9'(waddr0);
  assign wptr_x[1] = 9'(wptr1);  assign level_x[1] = 9'(level1);  assign waddr_x[1] = 9'(waddr1);
  assign wptr_x[2] = 9'(wptr2);  assign level_x[2] = 9'(level2);  assign waddr_x[2] = 9'(waddr2);
  assign wptr_x[3] = wptr3;      assign level_x[3] = level3;      assign waddr_x[3] = 9'(waddr3);

  function automatic logic [8:0] gray(input int b);
    logic [8:0] v;
    v = 9'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // random-phase reference model: plain write/read counts plus a delay line
  int wc [N];
  int rc [N];
  int hist [N][4];
  logic dexp [N];

  initial begin
    logic [2:0] seq [9];
    logic [2:0] fill_seq [3];
    logic [2:0] prev;
    seq      = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    fill_seq = '{3'b011, 3'b010, 3'b110};
    for (int k = 0; k < N; k++) begin
      push[k] = 1'b0;
      rptr_a[k] = '0;
    end

    // reset held with push asserted
    rst_n = 1'b0;
    push[0] = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wptr", wptr0, 0);
    chk("rst_full", full_x[0], 0);
    chk("rst_level", level0, 0);
    chk("rst_drop", drop_x[0], 0);
    chk("rst_waddr", waddr0, 0);
    chk("rst_we", we_x[0], 1);
    rst_n = 1'b1;

    // first push, then fill to full
    @(negedge clk); #1;
    chk("first_wptr", wptr0, 3'b001);
    chk("first_waddr", waddr0, 1);
    chk("first_level", level0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk($sformatf("fill_wptr%0d", i), wptr0, fill_seq[i]);
    end
    chk("full_set", full_x[0], 1);
    chk("full_level", level0, 4);
    chk("full_we", we_x[0], 0);
    @(negedge clk); #1;
    chk("full_hold", wptr0, 3'b110);
    chk("drop1", drop_x[0], 1);
    chk("full_we2", we_x[0], 0);
    @(negedge clk); #1;
    chk("drop2", drop_x[0], 1);
    push[0] = 1'b0;
    @(negedge clk); #1;
    chk("drop_clr", drop_x[0], 0);

    // read pointer advance while full; push in the same window is rejected
    rptr_a[0] = 9'(3'b001);
    push[0] = 1'b1;
    #1;
    chk("sync_we0", we_x[0], 0);
    @(negedge clk); #1;
    chk("sync_full_e1", full_x[0], 1);
    chk("sync_hold_e1", wptr0, 3'b110);
    push[0] = 1'b0;
    @(negedge clk); #1;
    chk("sync_full_e2", full_x[0], 0);
    chk("sync_level", level0, 3);

    // async reset mid-operation
    push[0] = 1'b1;
    @(negedge clk); #1;
    chk("pre_rst_wptr", wptr0, 3'b111);
    push[0] = 1'b0;
    rptr_a[0] = 9'(3'b101);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_wptr", wptr0, 0);
    chk("arst_full", full_x[0], 0);
    chk("arst_level", level0, 0);
    chk("arst_waddr", waddr0, 0);
    chk("arst_drop", drop_x[0], 0);
    #1 rst_n = 1'b1;
    rptr_a[0] = '0;
    push[0] = 1'b1;
    @(negedge clk); #1;
    chk("arst_push", wptr0, 3'b001);
    push[0] = 1'b0;

    // wrap-around with the reader one behind
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    chk("wrap_start", wptr0, seq[0]);
    for (int i = 0; i < 8; i++) begin
      push[0] = 1'b1;
      rptr_a[0] = (i == 0) ? 9'd0 : gray((i - 1) & 7);
      prev = wptr0;
      @(negedge clk); #1;
      chk($sformatf("wrap_wptr%0d", i), wptr0, seq[i+1]);
      chk($sformatf("wrap_1bit%0d", i), $countones(wptr0 ^ prev), 1);
      chk($sformatf("wrap_waddr%0d", i), waddr0, (i + 1) % 4);
    end
    push[0] = 1'b0;

    // random traffic on every parameterization
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) begin
      push[k] = 1'b0;
      rptr_a[k] = '0;
      wc[k] = 0;
      rc[k] = 0;
      dexp[k] = 1'b0;
      for (int j = 0; j < 4; j++) hist[k][j] = 0;
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int k = 0; k < N; k++) begin
        if (((cyc / 100) % 2) == 0) begin
          push[k] = ($urandom_range(3) != 0);
          if (rc[k] < wc[k] && $urandom_range(2) == 0) rc[k]++;
        end else begin
          push[k] = ($urandom_range(3) == 0);
          if (rc[k] < wc[k] && $urandom_range(3) != 0) rc[k]++;
        end
        rptr_a[k] = gray(rc[k] % (2 << AW[k]));
      end
      #1;
      for (int k = 0; k < N; k++) begin
        int depth, rs, lvl;
        logic efull;
        depth = 1 << AW[k];
        rs    = hist[k][SS[k]-1];
        lvl   = wc[k] - rs;
        efull = (lvl == depth);
        chk($sformatf("rnd_full[%0d]", k), full_x[k], efull);
        chk($sformatf("rnd_level[%0d]", k), level_x[k], lvl);
        chk($sformatf("rnd_waddr[%0d]", k), waddr_x[k], wc[k] % depth);
        chk($sformatf("rnd_wptr[%0d]", k), wptr_x[k], gray(wc[k] % (2 * depth)));
        chk($sformatf("rnd_we[%0d]", k), we_x[k], push[k] & ~efull);
        chk($sformatf("rnd_drop[%0d]", k), drop_x[k], dexp[k]);
        chk($sformatf("rnd_we_at_full[%0d]", k), we_x[k] && (level_x[k] == 9'(depth)), 0);
        dexp[k] = push[k] & efull;
        if (push[k] && !efull) wc[k]++;
        for (int j = 3; j > 0; j--) hist[k][j] = hist[k][j-1];
        hist[k][0] = rc[k];
      end
      @(negedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
